// File: rtl/io_pkg.sv
// Shared processor I/O package: interrupt FSM encoding and default port geometry.
package io_pkg;

    localparam int IO_WIDTH = 16;
    localparam int IO_NSRC  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_t;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry output FIFO with a registered head and a sticky drop flag.
module sync_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             full;
    logic             pop;
    logic             push;

    assign full      = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still take a write.
    assign push      = wr && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (wr && !push)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/io_int_ctrl.sv
// Interrupt controller with edge-triggered pending bits, a one-entry input port
// buffer and a two-entry output FIFO.
module io_int_ctrl
    import io_pkg::*;
#(
    parameter  int WIDTH = IO_WIDTH,
    parameter  int NSRC  = IO_NSRC,
    localparam int VW    = $clog2(NSRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  irq_src,
    input  logic [NSRC-1:0]  irq_en,
    output logic             interrupt,
    output logic [VW-1:0]    int_vec,
    input  logic             int_ack,
    input  logic             rti_done,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cpu_in_rd,
    output logic [WIDTH-1:0] inputPort,
    input  logic             cpu_out_wr,
    input  logic [WIDTH-1:0] cpu_out_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf
);

    // Lowest set index wins.
    function automatic logic [VW-1:0] prio_enc(input logic [NSRC-1:0] p);
        logic [VW-1:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (p[i]) r = VW'(i);
        return r;
    endfunction

    int_state_t      state;
    logic [NSRC-1:0] irq_prev;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] irq_edge;
    logic [NSRC-1:0] pend_clr;

    assign irq_edge = irq_src & ~irq_prev & irq_en;
    assign pend_clr = (state == ST_REQ && int_ack)
                    ? ({{(NSRC-1){1'b0}}, 1'b1} << int_vec) : '0;

    // A fresh edge on the source being acknowledged survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
            pend     <= '0;
        end else begin
            irq_prev <= irq_src;
            pend     <= (pend & ~pend_clr) | irq_edge;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
            int_vec   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (|pend) begin
                    state     <= ST_REQ;
                    int_vec   <= prio_enc(pend);
                    interrupt <= 1'b1;
                end
                ST_REQ: if (int_ack) begin
                    state     <= ST_SERVICE;
                    interrupt <= 1'b0;
                end
                ST_SERVICE: if (rti_done)
                    state <= ST_IDLE;
                default: begin
                    state     <= ST_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

    logic             alive;
    logic             full;
    logic [WIDTH-1:0] buf_data;
    logic             load;

    // alive holds in_ready low for the first cycle after reset release.
    assign in_ready = alive && !full;
    assign load     = in_valid && alive && (!full || cpu_in_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive     <= 1'b0;
            full      <= 1'b0;
            buf_data  <= '0;
            inputPort <= '0;
        end else begin
            alive <= 1'b1;
            if (cpu_in_rd)
                inputPort <= full ? buf_data : '0;
            if (load) begin
                buf_data <= in_data;
                full     <= 1'b1;
            end else if (cpu_in_rd) begin
                full <= 1'b0;
            end
        end
    end

    sync_fifo2 #(.WIDTH(WIDTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr        (cpu_out_wr),
        .wr_data   (cpu_out_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (out_ovf)
    );

endmodule

// File: doc/io_int_ctrl.md
IO_INT_CTRL -- requirements
Module: io_int_ctrl

Interface
REQ-001 Parameter WIDTH, 16, port data width.
REQ-002 Parameter NSRC, 4, number of external interrupt sources; NSRC is a power of 2 and at least 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 irq_src  input  NSRC  external interrupt request lines, level inputs, synchronous to clk.
REQ-006 irq_en  input  NSRC  per-source enable mask.
REQ-007 interrupt  output  1  interrupt request to the processor.
REQ-008 int_vec  output  log2(NSRC)  index of the source being serviced.
REQ-009 int_ack  input  1  one-cycle pulse: processor has entered the ISR.
REQ-010 rti_done  input  1  one-cycle pulse: processor has completed RTI.
REQ-011 in_data  input  WIDTH  external input-port data.
REQ-012 in_valid  input  1  external input-port data is valid.
REQ-013 in_ready  output  1  input-port buffer can accept data.
REQ-014 cpu_in_rd  input  1  processor IN instruction consumes the input port.
REQ-015 inputPort  output  WIDTH  data returned to the processor.
REQ-016 cpu_out_wr  input  1  processor OUT instruction write strobe.
REQ-017 cpu_out_data  input  WIDTH  processor OUT data.
REQ-018 out_data  output  WIDTH  head of the output FIFO.
REQ-019 out_valid  output  1  output FIFO is non-empty.
REQ-020 out_ready  input  1  external sink accepts out_data.
REQ-021 out_ovf  output  1  sticky flag: a processor write was dropped.

Function
REQ-022 Rising edge on irq_src[i] (previous cycle 0, current cycle 1) with irq_en[i]=1 shall set pend[i]; a high level without an edge shall not set it.
REQ-023 FSM IDLE->REQ when any pend bit is set; the lowest set index wins and is latched into int_vec on the transition.
REQ-024 In REQ, interrupt=1; int_ack moves the FSM to SERVICE, drops interrupt the next cycle, and clears pend[int_vec].
REQ-025 In SERVICE, interrupt=0 and new edges accumulate in pend; rti_done moves the FSM to IDLE.
REQ-026 int_ack outside REQ and rti_done outside SERVICE shall be ignored.
REQ-027 An edge on the source being acknowledged, in the same cycle as int_ack, shall leave pend set, because the set has priority over the clear.
REQ-028 int_vec shall hold its value from the REQ entry until the next REQ entry.
REQ-029 Input buffer holds 1 entry; in_ready = !full.
REQ-030 in_valid && in_ready shall load the buffer.
REQ-031 cpu_in_rd shall register the buffer contents to inputPort one cycle later and clear full.
REQ-032 cpu_in_rd on an empty buffer shall set inputPort to 0.
REQ-033 A load and a read in the same cycle with the buffer full: the read returns the old data, and the new data is loaded.
REQ-034 Output FIFO is 2 entries deep; out_data and out_valid come directly from registers (0-cycle head).
REQ-035 A pop occurs when out_valid && out_ready.
REQ-036 A push occurs on cpu_out_wr when not full, or when full with a pop in the same cycle.
REQ-037 cpu_out_wr while full with no pop shall drop the data and set out_ovf; out_ovf clears only on reset.
REQ-038 Pointers are 1 bit each plus a 2-bit count; count wraps never exceed 2.

Reset
REQ-039 During rst: FSM=IDLE, pend=0, the edge-detect history register=0, interrupt=0, int_vec=0.
REQ-040 During rst: in_ready=0, inputPort=0, buffer empty, out_valid=0, out_data=0, out_ovf=0, FIFO empty.
REQ-041 in_ready shall rise 1 cycle after rst deasserts.
REQ-042 Reset asserted mid-service shall abandon the service with no pending retained.

Structure
REQ-043 FSM state encoding (IDLE, REQ, SERVICE) and WIDTH/NSRC defaults shall live in the shared processor package io_pkg.
REQ-044 The output FIFO shall be one sub-module, sync_fifo2, parameterised by WIDTH.
REQ-045 The priority encoder shall be a combinational function inside io_int_ctrl.

Verification
REQ-046 irq_src=4'b0100 edge with irq_en=F: interrupt=1 in cycle 2 and int_vec=2; int_ack -> interrupt=0 and pend[2]=0; rti_done -> IDLE.
REQ-047 Edges on sources 3 and 1 in the same cycle: first service has int_vec=1; after rti_done, a second REQ has int_vec=3.
REQ-048 irq_src[0] held high across 10 cycles: exactly one interrupt; irq_en=0 at the edge gives no interrupt.
REQ-049 in_data=16'hBEEF with in_valid: in_ready=0 next cycle; cpu_in_rd -> inputPort=BEEF one cycle later, in_ready=1; cpu_in_rd while empty -> inputPort=0.
REQ-050 Three cpu_out_wr (0x11, 0x22, 0x33) with out_ready=0: FIFO holds 0x11 and 0x22, and out_ovf=1.
REQ-051 With the FIFO full, cpu_out_wr and out_ready in the same cycle: out_data=0x22 next and no overflow.
REQ-052 rst asserted in SERVICE with a pending edge: all outputs return to their reset values asynchronously.
